// File: rtl/sync_fifo_prog_if.sv
// Handshake and status bundle for sync_fifo_prog.
// The "master" modport drives requests and the "slave" modport is the FIFO.
interface sync_fifo_prog_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
);
    logic             i_flush;
    logic [WIDTH-1:0] i_data;
    logic             i_wr_en;
    logic             i_rd_en;
    logic [WIDTH-1:0] o_data;
    logic             o_valid;
    logic             o_full;
    logic             o_empty;
    logic             o_almost_full;
    logic             o_almost_empty;
    logic [CNT_W-1:0] o_count;
    logic             o_overflow;
    logic             o_underflow;

    modport master (
        output i_flush, i_data, i_wr_en, i_rd_en,
        input  o_data, o_valid, o_full, o_empty, o_almost_full, o_almost_empty,
               o_count, o_overflow, o_underflow
    );

    modport slave (
        input  i_flush, i_data, i_wr_en, i_rd_en,
        output o_data, o_valid, o_full, o_empty, o_almost_full, o_almost_empty,
               o_count, o_overflow, o_underflow
    );
endinterface

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO of arbitrary depth with programmable almost flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read port.
module sync_fifo_prog #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    sync_fifo_prog_if.slave fifo
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    generate
        if (!(AE_THRESH >= 0 && AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thresh
            $fatal(1, "sync_fifo_prog: need 0 <= AE_THRESH < AF_THRESH <= DEPTH");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;
    logic             full;
    logic             empty;
    logic             wr_req;
    logic             rd_req;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_comb begin
        full   = (count == CNT_W'(DEPTH));
        empty  = (count == '0);
        wr_req = fifo.i_wr_en & ~full;
        rd_req = fifo.i_rd_en & ~empty;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || fifo.i_flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_req) wr_ptr <= next_ptr(wr_ptr);
            if (rd_req) rd_ptr <= next_ptr(rd_ptr);
            case ({wr_req, rd_req})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (fifo.i_wr_en && full)  overflow  <= 1'b1;
            if (fifo.i_rd_en && empty) underflow <= 1'b1;
        end
    end

    // Storage has no reset; flush/reset only drop the same-cycle write.
    always_ff @(posedge i_clk) begin
        if (!i_rst && !fifo.i_flush && wr_req) mem[wr_ptr] <= fifo.i_data;
    end

    assign fifo.o_full         = full;
    assign fifo.o_empty        = empty;
    assign fifo.o_almost_full  = (count >= CNT_W'(AF_THRESH));
    assign fifo.o_almost_empty = (count <= CNT_W'(AE_THRESH));
    assign fifo.o_count        = count;
    assign fifo.o_overflow     = overflow;
    assign fifo.o_underflow    = underflow;

`ifdef SYNC_FIFO_FWFT_EN
    assign fifo.o_data  = mem[rd_ptr];
    assign fifo.o_valid = ~empty;
`else
    logic [WIDTH-1:0] rd_data_p1;
    logic             vld_p1;

    // Read stage p1: popped word presented for exactly one cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_data_p1 <= '0;
            vld_p1     <= 1'b0;
        end else if (fifo.i_flush) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= rd_req;
            if (rd_req) rd_data_p1 <= mem[rd_ptr];
        end
    end

    assign fifo.o_data  = rd_data_p1;
    assign fifo.o_valid = vld_p1;
`endif
endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: DEPTH=16 (AF=14, AE=2) and DEPTH=5 (AF=3, AE=1) instances.
module tb_sync_fifo_prog;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  sync_fifo_prog_if #(.WIDTH(8), .CNT_W(5)) f16 ();
  sync_fifo_prog_if #(.WIDTH(8), .CNT_W(3)) f5 ();

  sync_fifo_prog #(.WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)) dut16 (
    .i_clk(clk), .i_rst(rst), .fifo(f16)
  );
  sync_fifo_prog #(.WIDTH(8), .DEPTH(5), .AF_THRESH(3), .AE_THRESH(1)) dut5 (
    .i_clk(clk), .i_rst(rst), .fifo(f5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input bit ok, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic s16(input logic wr, input logic rd, input logic [7:0] din, input logic fl);
    f16.i_wr_en = wr; f16.i_rd_en = rd; f16.i_data = din; f16.i_flush = fl;
    @(posedge clk); #1;
    f16.i_wr_en = 1'b0; f16.i_rd_en = 1'b0; f16.i_flush = 1'b0;
  endtask

  task automatic s5(input logic wr, input logic rd, input logic [7:0] din);
    f5.i_wr_en = wr; f5.i_rd_en = rd; f5.i_data = din; f5.i_flush = 1'b0;
    @(posedge clk); #1;
    f5.i_wr_en = 1'b0; f5.i_rd_en = 1'b0;
  endtask

  task automatic rd16(input logic [7:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
    chk("rd16_valid", f16.o_valid === 1'b1, 32'(f16.o_valid), 32'd1);
    chk("rd16_data", f16.o_data === exp, 32'(f16.o_data), 32'(exp));
    s16(1'b0, 1'b1, 8'h00, 1'b0);
`else
    s16(1'b0, 1'b1, 8'h00, 1'b0);
    chk("rd16_valid", f16.o_valid === 1'b1, 32'(f16.o_valid), 32'd1);
    chk("rd16_data", f16.o_data === exp, 32'(f16.o_data), 32'(exp));
`endif
  endtask

  task automatic rd5(input logic [7:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
    chk("rd5_valid", f5.o_valid === 1'b1, 32'(f5.o_valid), 32'd1);
    chk("rd5_data", f5.o_data === exp, 32'(f5.o_data), 32'(exp));
    s5(1'b0, 1'b1, 8'h00);
`else
    s5(1'b0, 1'b1, 8'h00);
    chk("rd5_valid", f5.o_valid === 1'b1, 32'(f5.o_valid), 32'd1);
    chk("rd5_data", f5.o_data === exp, 32'(f5.o_data), 32'(exp));
`endif
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    f16.i_wr_en = 1'b0; f16.i_rd_en = 1'b0; f16.i_flush = 1'b0; f16.i_data = 8'h00;
    f5.i_wr_en  = 1'b0; f5.i_rd_en  = 1'b0; f5.i_flush  = 1'b0; f5.i_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    chk("rst_count", f16.o_count === 5'd0, 32'(f16.o_count), 32'd0);
    chk("rst_empty", f16.o_empty === 1'b1, 32'(f16.o_empty), 32'd1);
    chk("rst_full", f16.o_full === 1'b0, 32'(f16.o_full), 32'd0);
    chk("rst_ae", f16.o_almost_empty === 1'b1, 32'(f16.o_almost_empty), 32'd1);
    chk("rst_af", f16.o_almost_full === 1'b0, 32'(f16.o_almost_full), 32'd0);
    chk("rst_valid", f16.o_valid === 1'b0, 32'(f16.o_valid), 32'd0);
    chk("rst_ovf", f16.o_overflow === 1'b0, 32'(f16.o_overflow), 32'd0);
    chk("rst_unf", f16.o_underflow === 1'b0, 32'(f16.o_underflow), 32'd0);
    chk("rst5_empty", f5.o_empty === 1'b1, 32'(f5.o_empty), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rst_data", f16.o_data === 8'h00, 32'(f16.o_data), 32'd0);
`endif

    // fill and drain
    for (int i = 1; i <= 16; i++) s16(1'b1, 1'b0, 8'(i), 1'b0);
    chk("fill_count", f16.o_count === 5'd16, 32'(f16.o_count), 32'd16);
    chk("fill_full", f16.o_full === 1'b1, 32'(f16.o_full), 32'd1);
    chk("fill_af", f16.o_almost_full === 1'b1, 32'(f16.o_almost_full), 32'd1);
    for (int i = 1; i <= 16; i++) rd16(8'(i));
    chk("drain_empty", f16.o_empty === 1'b1, 32'(f16.o_empty), 32'd1);
    chk("drain_count", f16.o_count === 5'd0, 32'(f16.o_count), 32'd0);
    chk("drain_ovf", f16.o_overflow === 1'b0, 32'(f16.o_overflow), 32'd0);
    chk("drain_unf", f16.o_underflow === 1'b0, 32'(f16.o_underflow), 32'd0);

    // thresholds
    s16(1'b1, 1'b0, 8'h40, 1'b0);
    s16(1'b1, 1'b0, 8'h41, 1'b0);
    chk("ae_at2", f16.o_almost_empty === 1'b1, 32'(f16.o_almost_empty), 32'd1);
    s16(1'b1, 1'b0, 8'h42, 1'b0);
    chk("ae_at3", f16.o_almost_empty === 1'b0, 32'(f16.o_almost_empty), 32'd0);
    for (int i = 0; i < 10; i++) s16(1'b1, 1'b0, 8'(8'h50 + i), 1'b0);
    chk("af_count13", f16.o_count === 5'd13, 32'(f16.o_count), 32'd13);
    chk("af_at13", f16.o_almost_full === 1'b0, 32'(f16.o_almost_full), 32'd0);
    s16(1'b1, 1'b0, 8'h60, 1'b0);
    chk("af_at14", f16.o_almost_full === 1'b1, 32'(f16.o_almost_full), 32'd1);

    // simultaneous requests
    s16(1'b1, 1'b0, 8'h61, 1'b0);
    s16(1'b1, 1'b0, 8'h62, 1'b0);
    chk("sim_full16", f16.o_full === 1'b1, 32'(f16.o_full), 32'd1);
    s16(1'b1, 1'b1, 8'hEE, 1'b0);
    chk("sim_full_count", f16.o_count === 5'd15, 32'(f16.o_count), 32'd15);
    chk("sim_full_ovf", f16.o_overflow === 1'b1, 32'(f16.o_overflow), 32'd1);
    chk("sim_full_unf", f16.o_underflow === 1'b0, 32'(f16.o_underflow), 32'd0);
    for (int i = 0; i < 15; i++) s16(1'b0, 1'b1, 8'h00, 1'b0);
    chk("sim_drained", f16.o_count === 5'd0, 32'(f16.o_count), 32'd0);
    s16(1'b1, 1'b1, 8'h77, 1'b0);
    chk("sim_empty_count", f16.o_count === 5'd1, 32'(f16.o_count), 32'd1);
    chk("sim_empty_unf", f16.o_underflow === 1'b1, 32'(f16.o_underflow), 32'd1);
    for (int i = 0; i < 7; i++) s16(1'b1, 1'b0, 8'(8'h70 + i), 1'b0);
    s16(1'b1, 1'b1, 8'h7F, 1'b0);
    chk("sim_mid_count", f16.o_count === 5'd8, 32'(f16.o_count), 32'd8);

    // flush mid-operation
    s16(1'b1, 1'b0, 8'h80, 1'b0);
    chk("fl_pre_count", f16.o_count === 5'd9, 32'(f16.o_count), 32'd9);
    chk("fl_pre_ovf", f16.o_overflow === 1'b1, 32'(f16.o_overflow), 32'd1);
    s16(1'b1, 1'b0, 8'hEE, 1'b1);
    chk("fl_count", f16.o_count === 5'd0, 32'(f16.o_count), 32'd0);
    chk("fl_empty", f16.o_empty === 1'b1, 32'(f16.o_empty), 32'd1);
    chk("fl_ovf", f16.o_overflow === 1'b0, 32'(f16.o_overflow), 32'd0);
    chk("fl_unf", f16.o_underflow === 1'b0, 32'(f16.o_underflow), 32'd0);
    chk("fl_valid", f16.o_valid === 1'b0, 32'(f16.o_valid), 32'd0);
    s16(1'b1, 1'b0, 8'h5A, 1'b0);
    rd16(8'h5A);
    chk("fl_after_empty", f16.o_empty === 1'b1, 32'(f16.o_empty), 32'd1);

    // reset mid-operation
    for (int i = 0; i < 17; i++) s16(1'b1, 1'b0, 8'(8'h90 + i), 1'b0);
    for (int i = 0; i < 7; i++) s16(1'b0, 1'b1, 8'h00, 1'b0);
    chk("rs_pre_count", f16.o_count === 5'd9, 32'(f16.o_count), 32'd9);
    chk("rs_pre_ovf", f16.o_overflow === 1'b1, 32'(f16.o_overflow), 32'd1);
    rst = 1'b1; f16.i_wr_en = 1'b1; f16.i_data = 8'hEE;
    @(posedge clk); #1;
    rst = 1'b0; f16.i_wr_en = 1'b0;
    chk("rs_count", f16.o_count === 5'd0, 32'(f16.o_count), 32'd0);
    chk("rs_empty", f16.o_empty === 1'b1, 32'(f16.o_empty), 32'd1);
    chk("rs_ovf", f16.o_overflow === 1'b0, 32'(f16.o_overflow), 32'd0);
    chk("rs_valid", f16.o_valid === 1'b0, 32'(f16.o_valid), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rs_data", f16.o_data === 8'h00, 32'(f16.o_data), 32'd0);
`endif

    // read latency
    s16(1'b1, 1'b0, 8'hA5, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("lat_valid", f16.o_valid === 1'b1, 32'(f16.o_valid), 32'd1);
    chk("lat_data", f16.o_data === 8'hA5, 32'(f16.o_data), 32'hA5);
    s16(1'b0, 1'b1, 8'h00, 1'b0);
    chk("lat_pop_valid", f16.o_valid === 1'b0, 32'(f16.o_valid), 32'd0);
`else
    chk("lat_pre_valid", f16.o_valid === 1'b0, 32'(f16.o_valid), 32'd0);
    s16(1'b0, 1'b1, 8'h00, 1'b0);
    chk("lat_valid", f16.o_valid === 1'b1, 32'(f16.o_valid), 32'd1);
    chk("lat_data", f16.o_data === 8'hA5, 32'(f16.o_data), 32'hA5);
    s16(1'b0, 1'b0, 8'h00, 1'b0);
    chk("lat_valid_drop", f16.o_valid === 1'b0, 32'(f16.o_valid), 32'd0);
    chk("lat_data_hold", f16.o_data === 8'hA5, 32'(f16.o_data), 32'hA5);
`endif

    // non-power-of-two wrap
    for (int i = 0; i < 3; i++) s5(1'b1, 1'b0, 8'(8'h11 + i));
    for (int i = 0; i < 3; i++) rd5(8'(8'h11 + i));
    for (int i = 0; i < 5; i++) begin
      s5(1'b1, 1'b0, 8'(8'h21 + i));
      if (i == 3) chk("wrap_full4", f5.o_full === 1'b0, 32'(f5.o_full), 32'd0);
    end
    chk("wrap_full5", f5.o_full === 1'b1, 32'(f5.o_full), 32'd1);
    chk("wrap_count", f5.o_count === 3'd5, 32'(f5.o_count), 32'd5);
    chk("wrap_af", f5.o_almost_full === 1'b1, 32'(f5.o_almost_full), 32'd1);
    for (int i = 0; i < 5; i++) rd5(8'(8'h21 + i));
    chk("wrap_empty", f5.o_empty === 1'b1, 32'(f5.o_empty), 32'd1);
    chk("wrap_ovf", f5.o_overflow === 1'b0, 32'(f5.o_overflow), 32'd0);
    chk("wrap_unf", f5.o_underflow === 1'b0, 32'(f5.o_underflow), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
